fetch_sequencer: RTL and testbench

Fetch-stage controller that sequences the program counter into the combinational instruction memory and presents fetched instructions to decode through a registered valid/ready output stage. It owns the architectural fetch PC, applies jump/branch redirects with squash, honours decode backpressure, and supports halt/resume of instruction issue. It replaces the free-running PC register in front of the instruction memory; the memory itself stays a separate instance.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_sequencer.sv | 100 ++++++++++
 tb/tb_fetch_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Fetch-stage shared types and defaults.
package fetch_pkg;

   localparam int          PC_W_DEF     = 32;
   localparam int          IMEM_AW_DEF  = 10;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   // Sequencer control state; exported on dbg_state for observation.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

endpackage : fetch_pkg

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the fetch PC, drives the combinational instruction
// memory and registers fetched words into a valid/ready output slot.
//
// Output handshake: out_valid/out_inst/out_pc form a registered slot. A word
// transfers on a cycle where out_valid and out_ready are both high. While
// out_valid is high and out_ready is low the slot and the PC do not change.
// A redirect squashes the slot regardless of out_ready.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEF,
   parameter int              IMEM_AW  = IMEM_AW_DEF,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
   input  logic               clk,
   input  logic               rst,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_inst,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   input  logic               halt_req,
   input  logic               resume,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_inst,
   output logic [PC_W-1:0]    out_pc,
   output logic [PC_W-1:0]    out_pc_next,
   output logic               halted,
   output state_t             dbg_state
);

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic              out_valid_q, out_valid_d;
   logic [31:0]       out_inst_q, out_inst_d;
   logic [PC_W-1:0]   out_pc_q, out_pc_d;
   logic              fire;

   // Register all sequencer state; synchronous reset wins over every input.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         out_valid_q <= 1'b0;
         out_inst_q  <= 32'h0;
         out_pc_q    <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         out_valid_q <= out_valid_d;
         out_inst_q  <= out_inst_d;
         out_pc_q    <= out_pc_d;
      end
   end

   // Next-state, PC and output-slot update; redirect has top priority.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      out_valid_d = out_valid_q;
      out_inst_d  = out_inst_q;
      out_pc_d    = out_pc_q;
      fire        = (state_q == RUN) && !redirect_valid && !halt_req &&
                    (!out_valid_q || out_ready);

      // Slot and PC
      if (redirect_valid) begin
         pc_d        = redirect_pc;
         out_valid_d = 1'b0;
      end else if (fire) begin
         out_inst_d  = imem_inst;
         out_pc_d    = pc_q;
         out_valid_d = 1'b1;
         pc_d        = pc_q + PC_W'(1);
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      // Control state; a redirect does not block halt entry
      case (state_q)
         IDLE: state_d = RUN;
         RUN: begin
            if (halt_req) state_d = HALT;
         end
         HALT: begin
            if (!halt_req && resume) state_d = RUN;
         end
         default: state_d = IDLE;
      endcase
   end

   assign imem_addr   = pc_q[IMEM_AW-1:0];
   assign out_valid   = out_valid_q;
   assign out_inst    = out_inst_q;
   assign out_pc      = out_pc_q;
   assign out_pc_next = out_pc_q + PC_W'(1);
   assign halted      = (state_q == HALT) && !out_valid_q;
   assign dbg_state   = state_q;

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by random traffic,
// all compared against a transaction-level reference model.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  localparam int PC_W    = 32;
  localparam int IMEM_AW = 10;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_inst;
  logic               redirect_valid = 1'b0;
  logic [PC_W-1:0]    redirect_pc = '0;
  logic               halt_req = 1'b0;
  logic               resume = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [31:0]        out_inst;
  logic [PC_W-1:0]    out_pc;
  logic [PC_W-1:0]    out_pc_next;
  logic               halted;
  state_t             dbg_state;

  logic [31:0] mem [1024];
  assign imem_inst = mem[imem_addr];

  fetch_sequencer #(.PC_W(PC_W), .IMEM_AW(IMEM_AW), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_inst(imem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .resume(resume),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .out_pc_next(out_pc_next),
    .halted(halted), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // reference model: next PC to fetch, the presented word, and a mode
  // (0 warming up after reset, 1 issuing, 2 stopped)
  logic [31:0] m_pc, m_opc, m_inst;
  bit          m_vld;
  int          m_mode;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit taken, issue;
    if (rst) begin
      m_pc = 32'h0; m_opc = 32'h0; m_inst = 32'h0; m_vld = 0; m_mode = 0;
      return;
    end
    taken = m_vld && out_ready;
    issue = (m_mode == 1) && !redirect_valid && !halt_req && (!m_vld || out_ready);
    if (redirect_valid) begin
      m_pc  = redirect_pc;
      m_vld = 0;
    end else if (issue) begin
      m_inst = mem[m_pc % 1024];
      m_opc  = m_pc;
      m_pc   = m_pc + 1;
      m_vld  = 1;
    end else if (taken) begin
      m_vld = 0;
    end
    if (m_mode == 0) m_mode = 1;
    else if (m_mode == 1 && halt_req) m_mode = 2;
    else if (m_mode == 2 && resume && !halt_req) m_mode = 1;
  endtask

  task automatic compare_model();
    check("valid", 64'(out_valid), 64'(m_vld));
    check("imem_addr", 64'(imem_addr), 64'(m_pc % 1024));
    check("inst", 64'(out_inst), 64'(m_inst));
    check("pc", 64'(out_pc), 64'(m_opc));
    check("pc_next", 64'(out_pc_next), 64'(32'(m_opc + 1)));
    check("halted", 64'(halted), 64'((m_mode == 2) && !m_vld));
  endtask

  // driver: advance one cycle, update the model, then compare off the edge
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'h0511_0003;
    mem[1] = 32'h055d_0001;
    mem[2] = 32'h07b8_0000;
    mem[3] = 32'h0000_0000;

    // reset values
    tick(); tick();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'd0);
    check("rst_pc_next", 64'(out_pc_next), 64'd1);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    rst = 1'b0;

    // sequential stream from PC 0
    tick();
    check("idle_no_valid", 64'(out_valid), 64'd0);
    tick();
    check("seq0_pc", 64'(out_pc), 64'd0);
    check("seq0_inst", 64'(out_inst), 64'h0511_0003);
    tick();
    check("seq1_pc", 64'(out_pc), 64'd1);

    // backpressure at out_pc=1
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_inst", 64'(out_inst), 64'h055d_0001);
      check("bp_pc", 64'(out_pc), 64'd1);
      check("bp_addr", 64'(imem_addr), 64'd2);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_pc", 64'(out_pc), 64'd2);
    check("bp_release_inst", 64'(out_inst), 64'h07b8_0000);

    // redirect to 8 while out_pc=2 is valid and ready
    redirect_valid = 1'b1; redirect_pc = 32'd8;
    tick();
    redirect_valid = 1'b0;
    check("redir_squash", 64'(out_valid), 64'd0);
    tick();
    check("redir_pc", 64'(out_pc), 64'd8);
    check("redir_inst", 64'(out_inst), 64'(mem[8]));

    // halt with a pending word under backpressure
    out_ready = 1'b0; halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("halt_hold_valid", 64'(out_valid), 64'd1);
    check("halt_state", 64'(dbg_state), 64'(HALT));
    tick();
    check("halt_hold_pc", 64'(out_pc), 64'd8);
    check("halt_not_halted", 64'(halted), 64'd0);
    out_ready = 1'b1;
    tick();
    check("halt_halted", 64'(halted), 64'd1);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("resume_state", 64'(dbg_state), 64'(RUN));
    tick();
    check("resume_pc", 64'(out_pc), 64'd9);

    // PC crossing the memory index boundary
    redirect_valid = 1'b1; redirect_pc = 32'd1023;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("wrap_pc0", 64'(out_pc), 64'd1023);
    tick();
    check("wrap_pc1", 64'(out_pc), 64'd1024);
    check("wrap_inst", 64'(out_inst), 64'(mem[0]));
    check("wrap_pc_next", 64'(out_pc_next), 64'd1025);

    // reset mid-handshake
    out_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_addr", 64'(imem_addr), 64'd0);
    check("midrst_state", 64'(dbg_state), 64'(IDLE));
    rst = 1'b0;
    out_ready = 1'b1;

    // random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 2))
        0: redirect_pc = 32'($urandom_range(0, 2047));
        1: redirect_pc = 32'd1020 + 32'($urandom_range(0, 7));
        default: redirect_pc = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      endcase
      halt_req = ($urandom_range(0, 15) == 0);
      resume   = ($urandom_range(0, 3) == 0);
      rst      = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fetch_sequencer
